// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Optional build macro used elsewhere: RFARB_FIXED_PRIO_EN.
package regfile_pkg;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 5;
   localparam int REG_COUNT = 32;
   localparam int ZERO_REG  = 0;

   typedef enum logic {
      GNT_R0 = 1'b0,
      GNT_R1 = 1'b1
   } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer lives here.
// Handshake: a transfer happens in any cycle where req and gnt are both 1.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);
   import regfile_pkg::*;

   grant_t last_q, last_d;

   always_ff @(posedge clk) begin
      if (rst) last_q <= GNT_R1;
      else     last_q <= last_d;
   end

   // Contention goes to whichever requester was not granted last time.
   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      last_d = last_q;
      if (req0 && req1) begin
         if (last_q == GNT_R1) gnt0 = 1'b1;
         else                  gnt1 = 1'b1;
      end else if (req0) begin
         gnt0 = 1'b1;
      end else if (req1) begin
         gnt1 = 1'b1;
      end
      if (gnt0)      last_d = GNT_R0;
      else if (gnt1) last_d = GNT_R1;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares one register-file write port between ALU (r0) and load (r1) writeback.
// Build macro RFARB_FIXED_PRIO_EN selects fixed priority (r1 wins) instead of round-robin.
module regfile_wb_arbiter #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 r0_valid,
   output logic                 r0_ready,
   input  logic [ADDR_W-1:0]    r0_addr,
   input  logic [DATA_W-1:0]    r0_data,
   input  logic                 r1_valid,
   output logic                 r1_ready,
   input  logic [ADDR_W-1:0]    r1_addr,
   input  logic [DATA_W-1:0]    r1_data,
   input  logic                 alloc_valid,
   input  logic [ADDR_W-1:0]    alloc_addr,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_addr,
   output logic [DATA_W-1:0]    rf_wd,
   output logic [2**ADDR_W-1:0] busy
);
   import regfile_pkg::*;

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic                  gnt0, gnt1, xfer;
   logic [ADDR_W-1:0]     win_addr;
   logic [DATA_W-1:0]     win_data;
   logic [2**ADDR_W-1:0]  busy_d;

`ifdef RFARB_FIXED_PRIO_EN
   assign gnt1 = r1_valid;
   assign gnt0 = r0_valid & ~r1_valid;
`else
   rr_arbiter2 u_arb (
      .clk  (clk),
      .rst  (rst),
      .req0 (r0_valid),
      .req1 (r1_valid),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );
`endif

   assign r0_ready = gnt0;
   assign r1_ready = gnt1;
   assign xfer     = gnt0 | gnt1;
   assign win_addr = gnt1 ? r1_addr : r0_addr;
   assign win_data = gnt1 ? r1_data : r0_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we   <= 1'b0;
         rf_addr <= '0;
         rf_wd   <= '0;
      end else begin
         rf_we <= xfer && (win_addr != ZERO_ADDR);
         if (xfer) begin
            rf_addr <= win_addr;
            rf_wd   <= win_data;
         end
      end
   end

   // Clear after the write commits; a same-cycle alloc is a new producer so it wins.
   always_comb begin
      busy_d = busy;
      if (rf_we) busy_d[rf_addr] = 1'b0;
      if (alloc_valid && (alloc_addr != ZERO_ADDR)) busy_d[alloc_addr] = 1'b1;
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_d;
   end

endmodule
